// File: rtl/mem_access_stage_pkg.sv
// Shared width codes, write-back source codes and FSM state type for the
// memory-access stage.
package mem_access_stage_pkg;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: store replication/strobes and
// load extract with sign or zero extension. Width code 3 behaves as a word.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  st_width,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [1:0]  ld_width,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sign,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'hF;
    case (st_width)
      MEM_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr_lo;
      end
      MEM_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_rdata;
    case (ld_width)
      MEM_BYTE: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      MEM_HALF: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: performs the data-memory access over a req/ack port, stalls
// upstream while it is outstanding and registers the MEM/WB result.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses (misalign_o).
//
// state  | meaning
// IDLE   | accept EX/MEM entry; non-memory ops write back on the next edge
// ACCESS | request outstanding; wait for dmem_ack_i or timeout
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] advance_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] reg_2_data_i,
  input  logic [4:0]  reg_write_data_addr_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_sign_extend_i,
  input  logic [1:0]  reg_src_i,
  input  logic        mem_write_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [29:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        bus_err_o
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        mem_op, trap, timeout;
  logic        lat_load, lat_sign;
  logic [4:0]  lat_rd;
  logic [1:0]  lat_width, lat_lo;
  logic [31:0] st_wdata, ld_data, wb_sel_data;
  logic [3:0]  st_wstrb;

  assign mem_op = valid_i & (mem_write_i | (reg_src_i == WB_MEM));

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((mem_width_i == MEM_HALF) & alu_result_i[0]) |
                      (mem_width_i[1] & (alu_result_i[1:0] != 2'b00));
  assign trap = mem_op & misaligned;
`else
  assign trap = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .st_width   (mem_width_i),
    .st_addr_lo (alu_result_i[1:0]),
    .st_data    (reg_2_data_i),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .ld_width   (lat_width),
    .ld_addr_lo (lat_lo),
    .ld_sign    (lat_sign),
    .ld_rdata   (dmem_rdata_i),
    .ld_data    (ld_data)
  );

  always_comb begin
    case (reg_src_i)
      WB_ALU:  wb_sel_data = alu_result_i;
      WB_PC:   wb_sel_data = advance_pc_i;
      default: wb_sel_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !trap) begin
          stall_o   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        timeout = !dmem_ack_i && (wait_cnt == WAIT_LAST);
        stall_o = !dmem_ack_i && !timeout;
        if (dmem_ack_i || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= 8'd0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 30'd0;
      dmem_wdata_o <= 32'h0;
      dmem_wstrb_o <= 4'h0;
      lat_load     <= 1'b0;
      lat_sign     <= 1'b0;
      lat_rd       <= 5'd0;
      lat_width    <= 2'd0;
      lat_lo       <= 2'd0;
      wb_we_o      <= 1'b0;
      wb_addr_o    <= 5'd0;
      wb_data_o    <= 32'h0;
      bus_err_o    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o   <= 1'b0;
`endif
    end else begin
      bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= trap;
`endif
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (mem_op && !trap) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_write_i;
            dmem_addr_o  <= alu_result_i[31:2];
            dmem_wdata_o <= st_wdata;
            dmem_wstrb_o <= mem_write_i ? st_wstrb : 4'h0;
            lat_load     <= !mem_write_i;
            lat_sign     <= mem_sign_extend_i;
            lat_rd       <= reg_write_data_addr_i;
            lat_width    <= mem_width_i;
            lat_lo       <= alu_result_i[1:0];
            wb_we_o      <= 1'b0;
          end else begin
            // A trapped access is a memory op, so it never writes back.
            wb_we_o   <= valid_i && !mem_op && (reg_src_i != WB_NONE) &&
                         (reg_write_data_addr_i != 5'd0);
            wb_addr_o <= reg_write_data_addr_i;
            wb_data_o <= wb_sel_data;
          end
        end
        ACCESS: begin
          if (dmem_ack_i || timeout) begin
            dmem_req_o <= 1'b0;
            wait_cnt   <= 8'd0;
            bus_err_o  <= timeout;
            wb_we_o    <= lat_load && (lat_rd != 5'd0);
            wb_addr_o  <= lat_rd;
            wb_data_o  <= dmem_ack_i ? ld_data : 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            wb_we_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
